// File: rtl/data_mem_unit_if.sv
// Request/response bundle between the pipeline and the data-memory stage.
// The master (core side) issues requests, the slave (memory stage) responds.
interface data_mem_unit_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        misalign;

  modport master (
    output req, we, size, sign_ext, addr, wdata,
    input  rdata, ready, busy, misalign
  );

  modport slave (
    input  req, we, size, sign_ext, addr, wdata,
    output rdata, ready, busy, misalign
  );
endinterface

// File: rtl/data_mem_unit.sv
// Data-memory stage: byte/half/word loads and stores into a word-organised RAM,
// with sign/zero extension, misalignment rejection and optional wait states.
module data_mem_unit #(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic          clk,
  input  logic          rst,
  data_mem_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  // Halfwords need an even address, words a 4-byte aligned one; size 11 never fits.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = lane[0];
      2'b10:   is_misaligned = (lane != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   lane_mask = 4'b0001 << lane;
      2'b01:   lane_mask = lane[1] ? 4'b1100 : 4'b0011;
      2'b10:   lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  // Store data is replicated across lanes so the byte mask alone selects the target.
  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'b00:   lane_data = {4{wdata[7:0]}};
      2'b01:   lane_data = {2{wdata[15:0]}};
      default: lane_data = wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic sx);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   load_extract = {{24{sx & b[7]}}, b};
      2'b01:   load_extract = {{16{sx & h[15]}}, h};
      2'b10:   load_extract = word;
      default: load_extract = 32'h0000_0000;
    endcase
  endfunction

  logic [31:0] mem [0:(1 << ADDR_BITS) - 1];

  state_t                 state, state_next;
  logic [3:0]             cnt, cnt_next;
  logic                   latch_en, commit;
  logic                   we_r, sx_r;
  logic [1:0]             size_r, lane_r;
  logic [ADDR_BITS-1:0]   idx_r;
  logic [31:0]            wdata_r;
  logic [31:0]            rdata_r;
  logic                   ready_r, busy_r, misalign_r;

  logic                   op_we, op_sx;
  logic [1:0]             op_size, op_lane;
  logic [ADDR_BITS-1:0]   op_idx;
  logic [31:0]            op_wdata;
  logic                   op_mis;
  logic [3:0]             byte_en;
  logic [31:0]            wr_word;
  logic [31:0]            load_val;

  logic unused_addr;
  assign unused_addr = ^bus.addr[31:ADDR_BITS+2];

  // Next state: accept in IDLE, count down in WAIT, single response cycle in DONE.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    latch_en   = 1'b0;
    commit     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.req) begin
          latch_en = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_next = S_WAIT;
            cnt_next   = WAIT_LOAD;
          end else begin
            state_next = S_DONE;
            commit     = 1'b1;
          end
        end else begin
          state_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_next = S_DONE;
          commit     = 1'b1;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // With no wait states the access commits on the accept edge, so use live inputs in IDLE.
  always_comb begin
    if (state == S_IDLE) begin
      op_we    = bus.we;
      op_sx    = bus.sign_ext;
      op_size  = bus.size;
      op_lane  = bus.addr[1:0];
      op_idx   = bus.addr[ADDR_BITS+1:2];
      op_wdata = bus.wdata;
    end else begin
      op_we    = we_r;
      op_sx    = sx_r;
      op_size  = size_r;
      op_lane  = lane_r;
      op_idx   = idx_r;
      op_wdata = wdata_r;
    end
  end

  // Lane enables and load extraction for the access committing this cycle.
  always_comb begin
    op_mis   = is_misaligned(op_size, op_lane);
    wr_word  = lane_data(op_size, op_wdata);
    load_val = load_extract(mem[op_idx], op_size, op_lane, op_sx);
    if (commit && op_we && !op_mis && !rst) begin
      byte_en = lane_mask(op_size, op_lane);
    end else begin
      byte_en = 4'b0000;
    end
  end

  // Control state, latched request and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      we_r       <= 1'b0;
      sx_r       <= 1'b0;
      size_r     <= 2'b00;
      lane_r     <= 2'b00;
      idx_r      <= '0;
      wdata_r    <= 32'h0000_0000;
      rdata_r    <= 32'h0000_0000;
      ready_r    <= 1'b0;
      busy_r     <= 1'b0;
      misalign_r <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      ready_r <= commit;
      busy_r  <= (state_next != S_IDLE);
      if (latch_en) begin
        we_r    <= bus.we;
        sx_r    <= bus.sign_ext;
        size_r  <= bus.size;
        lane_r  <= bus.addr[1:0];
        idx_r   <= bus.addr[ADDR_BITS+1:2];
        wdata_r <= bus.wdata;
      end
      if (commit) begin
        misalign_r <= op_mis;
        rdata_r    <= (op_we || op_mis) ? 32'h0000_0000 : load_val;
      end else begin
        misalign_r <= 1'b0;
      end
    end
  end

  // Byte-lane RAM write; the reset term is folded into byte_en so reset wins.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) begin
        mem[op_idx][i*8 +: 8] <= wr_word[i*8 +: 8];
      end
    end
  end

  assign bus.rdata    = rdata_r;
  assign bus.ready    = ready_r;
  assign bus.busy     = busy_r;
  assign bus.misalign = misalign_r;

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: a vector table on a zero-wait instance, plus
// hand-written wait-state and reset sequences on a WAIT_CYCLES=3 instance.
module tb_data_mem_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst3;
  data_mem_unit_if bus0();
  data_mem_unit_if bus3();

  data_mem_unit #(.ADDR_BITS(10), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst0), .bus(bus0));
  data_mem_unit #(.ADDR_BITS(10), .WAIT_CYCLES(3)) dut3 (.clk(clk), .rst(rst3), .bus(bus3));

  typedef struct {
    string       nm;
    logic        we;
    logic [1:0]  size;
    logic        sx;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   nvec = 0;
  int   nmis = 0;

  function automatic vec_t mk(input string nm, input logic we, input logic [1:0] size,
                              input logic sx, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_mis);
    vec_t v;
    v.nm = nm; v.we = we; v.size = size; v.sx = sx; v.addr = addr;
    v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_mis = exp_mis;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic rq, input vec_t v);
    if (sel == 0) begin
      bus0.req = rq; bus0.we = v.we; bus0.size = v.size; bus0.sign_ext = v.sx;
      bus0.addr = v.addr; bus0.wdata = v.wdata;
    end else begin
      bus3.req = rq; bus3.we = v.we; bus3.size = v.size; bus3.sign_ext = v.sx;
      bus3.addr = v.addr; bus3.wdata = v.wdata;
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 0) ? bus0.ready : bus3.ready;
  endfunction
  function automatic logic bsy(input int sel);
    return (sel == 0) ? bus0.busy : bus3.busy;
  endfunction
  function automatic logic msa(input int sel);
    return (sel == 0) ? bus0.misalign : bus3.misalign;
  endfunction
  function automatic logic [31:0] rdt(input int sel);
    return (sel == 0) ? bus0.rdata : bus3.rdata;
  endfunction

  // One request: drive it, push the expectation, wait (bounded) for ready, compare.
  task automatic access(input int sel, input vec_t v);
    exp_t e;
    int   lat;
    int   c;
    bit   seen;
    lat = (sel == 0) ? 1 : 4;
    @(negedge clk);
    drive(sel, 1'b1, v);
    e.rdata = v.exp_rdata;
    e.mis   = v.exp_mis;
    sb.push_back(e);
    @(negedge clk);
    drive(sel, 1'b0, v);
    c = 1;
    seen = 1'b0;
    while (!seen && c <= 20) begin
      if (rdy(sel)) begin
        seen = 1'b1;
      end else begin
        @(negedge clk);
        c++;
      end
    end
    check({v.nm, "_latency"}, seen ? 32'(c) : 32'hFFFF_FFFF, 32'(lat));
    e = sb.pop_front();
    if (seen) begin
      check({v.nm, "_rdata"}, rdt(sel), e.rdata);
      check({v.nm, "_misalign"}, 32'(msa(sel)), 32'(e.mis));
      check({v.nm, "_busy"}, 32'(bsy(sel)), 32'd1);
      @(negedge clk);
      check({v.nm, "_ready_pulse"}, 32'(rdy(sel)), 32'd0);
      check({v.nm, "_rdata_hold"}, rdt(sel), e.rdata);
    end
  endtask

  // Count ready pulses over n cycles on the given instance.
  task automatic count_ready(input int sel, input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rdy(sel)) cnt++;
    end
  endtask

  initial begin
    vec_t v;
    int   extra;
    bit   busy_ok;
    bit   rdy_bad;

    vecs.push_back(mk("sw_10",      1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678, 32'h0, 1'b0));
    vecs.push_back(mk("lw_10",      1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h1234_5678, 1'b0));
    vecs.push_back(mk("sw_20",      1'b1, 2'b10, 1'b0, 32'h20, 32'h80FF_7F01, 32'h0, 1'b0));
    vecs.push_back(mk("lb_23",      1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 32'hFFFF_FF80, 1'b0));
    vecs.push_back(mk("lbu_23",     1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 32'h0000_0080, 1'b0));
    vecs.push_back(mk("lh_20",      1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 32'h0000_7F01, 1'b0));
    vecs.push_back(mk("lh_22",      1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 32'hFFFF_80FF, 1'b0));
    vecs.push_back(mk("lhu_22",     1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'h0000_80FF, 1'b0));
    vecs.push_back(mk("sw_30",      1'b1, 2'b10, 1'b0, 32'h30, 32'hAAAA_AAAA, 32'h0, 1'b0));
    vecs.push_back(mk("sb_31",      1'b1, 2'b00, 1'b0, 32'h31, 32'hFFFF_FF55, 32'h0, 1'b0));
    vecs.push_back(mk("sh_32",      1'b1, 2'b01, 1'b0, 32'h32, 32'hABCD_1234, 32'h0, 1'b0));
    vecs.push_back(mk("lw_30",      1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'h1234_55AA, 1'b0));
    vecs.push_back(mk("lw_31_mis",  1'b0, 2'b10, 1'b0, 32'h31, 32'h0, 32'h0, 1'b1));
    vecs.push_back(mk("sh_33_mis",  1'b1, 2'b01, 1'b0, 32'h33, 32'hFFFF_FFFF, 32'h0, 1'b1));
    vecs.push_back(mk("lz11_40",    1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 32'h0, 1'b1));
    vecs.push_back(mk("sz11_30",    1'b1, 2'b11, 1'b0, 32'h30, 32'h0, 32'h0, 1'b1));
    vecs.push_back(mk("sw_31_mis",  1'b1, 2'b10, 1'b0, 32'h31, 32'h0, 32'h0, 1'b1));
    vecs.push_back(mk("lw_30_again",1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'h1234_55AA, 1'b0));
    vecs.push_back(mk("lb_30",      1'b0, 2'b00, 1'b1, 32'h30, 32'h0, 32'hFFFF_FFAA, 1'b0));
    vecs.push_back(mk("lb_31",      1'b0, 2'b00, 1'b1, 32'h31, 32'h0, 32'h0000_0055, 1'b0));
    vecs.push_back(mk("sw_1000",    1'b1, 2'b10, 1'b0, 32'h1000, 32'hCAFE_F00D, 32'h0, 1'b0));
    vecs.push_back(mk("lw_0_wrap",  1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'hCAFE_F00D, 1'b0));

    // Reset state on both instances.
    rst0 = 1'b1;
    rst3 = 1'b1;
    v = mk("idle", 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    drive(0, 1'b0, v);
    drive(1, 1'b0, v);
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("reset_rdata", rdt(s), 32'h0);
      check("reset_ready", 32'(rdy(s)), 32'd0);
      check("reset_busy", 32'(bsy(s)), 32'd0);
      check("reset_misalign", 32'(msa(s)), 32'd0);
    end
    rst0 = 1'b0;
    rst3 = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      access(0, vecs[i]);
    end

    // Three wait states: busy for four cycles, ready only on the fourth, req pulses ignored.
    v = mk("w3_sw_60", 1'b1, 2'b10, 1'b0, 32'h60, 32'h1122_3344, 32'h0, 1'b0);
    @(negedge clk);
    drive(1, 1'b1, v);
    @(negedge clk);
    drive(1, 1'b0, v);
    busy_ok = 1'b1;
    rdy_bad = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (!bsy(1)) busy_ok = 1'b0;
      if (rdy(1) != (c == 4)) rdy_bad = 1'b1;
      if (c == 1 || c == 4) drive(1, 1'b1, v);
      else drive(1, 1'b0, v);
      if (c < 4) @(negedge clk);
    end
    check("w3_busy_window", 32'(busy_ok), 32'd1);
    check("w3_ready_only_at_4", 32'(rdy_bad), 32'd0);
    @(negedge clk);
    drive(1, 1'b0, v);
    check("w3_busy_after", 32'(bsy(1)), 32'd0);
    count_ready(1, 10, extra);
    check("w3_no_second_ready", 32'(extra), 32'd0);
    access(1, mk("w3_lw_60", 1'b0, 2'b10, 1'b0, 32'h60, 32'h0, 32'h1122_3344, 1'b0));

    // Reset while waiting aborts the store.
    access(1, mk("w3_sw_50", 1'b1, 2'b10, 1'b0, 32'h50, 32'h5A5A_5A5A, 32'h0, 1'b0));
    v = mk("w3_abort", 1'b1, 2'b10, 1'b0, 32'h50, 32'hDEAD_BEEF, 32'h0, 1'b0);
    @(negedge clk);
    drive(1, 1'b1, v);
    @(negedge clk);
    drive(1, 1'b0, v);
    rst3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0;
    check("rst_wait_busy", 32'(bsy(1)), 32'd0);
    count_ready(1, 8, extra);
    check("rst_wait_no_ready", 32'(extra), 32'd0);
    access(1, mk("rst_wait_lw_50", 1'b0, 2'b10, 1'b0, 32'h50, 32'h0, 32'h5A5A_5A5A, 1'b0));

    // Reset coinciding with the commit edge suppresses the write.
    v = mk("w3_commit_rst", 1'b1, 2'b10, 1'b0, 32'h50, 32'h7777_7777, 32'h0, 1'b0);
    @(negedge clk);
    drive(1, 1'b1, v);
    @(negedge clk);
    drive(1, 1'b0, v);
    @(negedge clk);
    @(negedge clk);
    rst3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0;
    check("rst_commit_ready", 32'(rdy(1)), 32'd0);
    count_ready(1, 8, extra);
    check("rst_commit_no_ready", 32'(extra), 32'd0);
    access(1, mk("rst_commit_lw_50", 1'b0, 2'b10, 1'b0, 32'h50, 32'h0, 32'h5A5A_5A5A, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/data_mem_unit.md
Name: data_mem_unit

Overview:
- Data-memory stage that sits directly downstream of the ALU.
- Takes the ALU result as the effective address and the register-file rt value as store data.
- Performs byte, halfword and word loads and stores against an internal word-organised RAM, with sign or zero extension on loads and misalignment detection.
- A req/ready handshake and a configurable wait-state counter let the same block serve the single-cycle core (WAIT_CYCLES=0) and later multi-cycle/pipelined cores.

Parameters:
- ADDR_BITS, 10, word-index width; RAM holds 2^ADDR_BITS 32-bit words.
- WAIT_CYCLES, 0, extra access cycles inserted between request accept and response (0..15).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  1  access request; sampled only in IDLE.
- we  input  1  1=store, 0=load; sampled with req.
- size  input  2  00=byte, 01=halfword, 10=word, 11=reserved (treated as misaligned).
- sign_ext  input  1  loads only: 1=sign-extend, 0=zero-extend.
- addr  input  32  byte address (ALU result).
- wdata  input  32  store data; byte/half taken from low bits.
- rdata  output  32  load result, valid while ready=1.
- ready  output  1  one-cycle response pulse.
- busy  output  1  high while a request is in flight (WAIT or DONE).
- misalign  output  1  valid with ready: access rejected.

Behaviour:
- Reset values: rdata=0, ready=0, busy=0, misalign=0, state=IDLE, wait counter=0. RAM contents are not cleared.
- FSM states IDLE, WAIT, DONE:
  - IDLE and req=1: latch we, size, sign_ext, addr, wdata. Go to WAIT if WAIT_CYCLES>0 (counter loaded with WAIT_CYCLES-1), else DONE.
  - WAIT: counter decrements each cycle; at 0, go to DONE.
  - DONE: ready=1 for exactly one cycle; go to IDLE.
  - req in WAIT or DONE is ignored (not queued). The requester holds req low or re-asserts after ready.
- Latency: req sampled at edge N gives ready=1 during cycle N+1+WAIT_CYCLES. Max throughput is one access per 2+WAIT_CYCLES cycles.
- busy=1 in WAIT and DONE, 0 in IDLE.
- Address mapping:
  - word index = addr[ADDR_BITS+1:2]; upper address bits are ignored, so addresses wrap modulo 2^(ADDR_BITS+2).
  - byte lane = addr[1:0], little-endian (lane 0 = bits 7:0).
- Alignment:
  - byte: any address.
  - half: addr[0]=0.
  - word: addr[1:0]=00.
  - size=11: always misaligned.
  - Misaligned access: no RAM write. Response timing is unchanged; in the ready cycle misalign=1 and rdata=0.
- Store commit:
  - Occurs on the clock edge that enters DONE; only the enabled byte lanes are written.
  - sb writes wdata[7:0] to the selected lane; sh writes wdata[15:0] to lanes {1,0} or {3,2}; sw writes all four lanes.
  - rdata=0 for stores.
- Load: RAM word read at the same edge; the selected byte/half is extended per sign_ext into rdata, which is registered and held until the next response. misalign=0.
- Outputs outside the ready cycle: ready=0, misalign=0, rdata holds its last value.
- Reset mid-operation: rst in WAIT aborts the access with no write and no ready pulse. rst in DONE clears ready the following cycle. A store whose commit edge coincides with rst is not written (reset has priority).
- Load after store to the same word returns the new data (store commits before the next request can be accepted).
- RAM is inferred as synchronous-write memory with no reset.

Test Plan:
- WAIT_CYCLES=0: sw 0x12345678 to addr 0x10, then lw 0x10 -> ready exactly 1 cycle after each req edge; rdata=0x12345678, misalign=0.
- Byte/half extension: after sw 0x80FF7F01 at 0x20 -> lb 0x23 sign_ext=1 gives 0xFFFFFF80; lbu 0x23 gives 0x00000080; lh 0x20 gives 0x00007F01; lh 0x22 sign_ext=1 gives 0xFFFF80FF.
- Partial store: sw 0xAAAAAAAA at 0x30, sb wdata=0x55 at 0x31, sh wdata=0x1234 at 0x32 -> lw 0x30 = 0x1234_55AA.
- Misalignment: lw 0x31, sh 0x33, size=11 at 0x40 -> each gives ready with misalign=1, rdata=0; a following lw 0x30 still returns 0x123455AA (no write occurred).
- WAIT_CYCLES=3: req at edge N -> busy=1 for cycles N+1..N+4, ready only at N+4; req pulses during busy are ignored (no second ready).
- Reset/wrap: rst asserted in WAIT of sw 0xDEADBEEF at 0x50 -> no ready, word unchanged; with ADDR_BITS=10, sw 0xCAFEF00D at 0x1000 then lw 0x0 -> 0xCAFEF00D.
